dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words in the backing array.
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  request valid, held high by the pipeline until the access is consumed.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wmask  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-009 SHALL have port wdata  input  32  lane-aligned store data.
REQ-010 SHALL have port is_fire  input  1  pipeline consumed the current response.
REQ-011 SHALL have port rdata  output  32  full loaded word (lane extraction is done by the pipeline).
REQ-012 SHALL have port rdata_valid  output  1  load complete; rdata valid.
REQ-013 SHALL have port write_finish  output  1  store committed.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE; encoding is free.
REQ-015 SHALL, in IDLE with en=1, latch addr, we, wmask, wdata and load a 4-bit counter with LATENCY-1, entering BUSY.
REQ-016 SHALL ignore we, addr, wmask, wdata in BUSY and DONE; only the latched copies are used.
REQ-017 SHALL, in BUSY with counter nonzero and en=1, decrement the counter.
REQ-018 SHALL, in BUSY with counter zero and en=1, perform the access and enter DONE, so the response is first visible LATENCY cycles after the accepting edge.
REQ-019 SHALL index the array with latched addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above DEPTH_LOG2+1 are ignored (address wraps modulo array size).
REQ-020 SHALL, on a load completion, register the array word into rdata and set rdata_valid=1, write_finish=0.
REQ-021 SHALL, on a store completion, write only byte lanes with wmask bit set, set write_finish=1, rdata_valid=0, and leave rdata unchanged.
REQ-022 SHALL, for a load completion on the same edge that no store occurs, return the contents including all previously completed stores (read-after-write across requests is coherent).
REQ-023 SHALL, in DONE, hold rdata, rdata_valid, write_finish stable while en=1 and is_fire=0.
REQ-024 SHALL, in DONE with is_fire=1, clear rdata_valid and write_finish and enter IDLE; the next request is accepted no earlier than the following edge.
REQ-025 SHALL, in BUSY with en=0 (pipeline flush), abort: enter IDLE, no array write, outputs unchanged low.
REQ-026 SHALL, in DONE with en=0, clear rdata_valid and write_finish and enter IDLE; a completed store remains committed.
REQ-027 SHALL never assert rdata_valid and write_finish together.
REQ-028 SHALL treat a store with wmask=4'b0000 as a normal store: write_finish pulses, array unchanged.
REQ-029 SHALL ignore is_fire outside DONE.

Reset
REQ-030 SHALL on reset force state IDLE, counter 0, rdata=32'h0, rdata_valid=0, write_finish=0, latched request fields 0, asynchronously.
REQ-031 SHALL not clear the array contents on reset.
REQ-032 SHALL, if reset asserts during BUSY, discard the pending access with no array write.

Verification
REQ-033 LATENCY=1: store addr=0x10 wdata=0xDEADBEEF wmask=4'b1111 en=1 at edge 0 -> write_finish=1 after edge 1, held until is_fire; then load addr=0x10 -> rdata=0xDEADBEEF, rdata_valid=1 one edge after acceptance.
REQ-034 Byte lane: preload 0x11223344 at 0x20, store wdata=0x0000AA00 wmask=4'b0010 -> load 0x20 returns 0x1122AA44.
REQ-035 LATENCY=3: load accepted at edge 0 -> rdata_valid low after edges 1,2, high after edge 3; is_fire held low 5 cycles -> rdata_valid and rdata stable throughout.
REQ-036 Flush: LATENCY=4 store to 0x40 value 0x55 accepted, en dropped after edge 2 -> state IDLE, write_finish never asserts, later load 0x40 returns prior contents.
REQ-037 Wrap: DEPTH_LOG2=10, store 0x12345678 to addr 0x00001004 -> load addr 0x00000004 returns 0x12345678.
REQ-038 Async reset asserted mid-DONE with rdata_valid=1 -> rdata_valid=0, rdata=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for a pipelined core.
// A request held on en is accepted in IDLE, waits LATENCY cycles in BUSY,
// then completes (load -> rdata/rdata_valid, store -> write_finish) and
// holds the response in DONE until the pipeline consumes it (is_fire) or
// drops the request (en low).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   en           request valid, held until consumed
//   we           1 = store, 0 = load
//   addr[31:0]   byte address; word index addr[DEPTH_LOG2+1:2]
//   wmask[3:0]   byte-lane write enables
//   wdata[31:0]  lane-aligned store data
//   is_fire      pipeline consumed the current response
//   rdata[31:0]  loaded word (registered)
//   rdata_valid  load complete
//   write_finish store committed

// One byte lane of the backing array. Not reset: contents survive reset.
module dmem_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [7:0]            wbyte,
  output logic [7:0]            rbyte
);
  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk)
    if (wr) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        is_fire,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        write_finish
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                          state;
  logic [3:0]                      cnt;
  logic                            we_q;
  logic [DEPTH_LOG2-1:0]           idx_q;
  logic [NUM_LANES-1:0]            wmask_q;
  logic [NUM_LANES-1:0][7:0]       wdata_q;
  logic [NUM_LANES-1:0][7:0]       rword;
  logic                            access;
  logic                            wr_go;

  // Only the word index is kept; byte offset and high bits never matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  // Completion edge: counter exhausted and the pipeline still wants it.
  assign access = (state == BUSY) && en && (cnt == 4'd0);
  // Gate with reset so a reset coinciding with the completion edge drops the store.
  assign wr_go  = access && we_q && !reset;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dmem_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
        .clk   (clk),
        .wr    (wr_go & wmask_q[i]),
        .idx   (idx_q),
        .wbyte (wdata_q[i]),
        .rbyte (rword[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      rdata        <= 32'h0;
      rdata_valid  <= 1'b0;
      write_finish <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          we_q    <= we;
          idx_q   <= addr[DEPTH_LOG2+1:2];
          wmask_q <= wmask;
          wdata_q <= wdata;
          cnt     <= CNT_INIT;
          state   <= BUSY;
        end
        BUSY: begin
          if (!en) begin
            state <= IDLE;            // flush: nothing written, outputs stay low
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (we_q) begin
              write_finish <= 1'b1;   // rdata keeps the last loaded word
              rdata_valid  <= 1'b0;
            end else begin
              rdata        <= rword;
              rdata_valid  <= 1'b1;
              write_finish <= 1'b0;
            end
            state <= DONE;
          end
        end
        DONE: if (!en || is_fire) begin
          rdata_valid  <= 1'b0;
          write_finish <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=3, DEPTH_LOG2=10).
// A transaction-level model (word array + expected output registers updated
// at the edges where the response rules say they change) is compared with
// the DUT on every falling edge; literal expectations pin key results.
module tb_dmem_responder;
  localparam int LAT   = 3;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic        clk, reset, en, we, is_fire;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        rdata_valid, write_finish;

  dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .we           (we),
    .addr         (addr),
    .wmask        (wmask),
    .wdata        (wdata),
    .is_fire      (is_fire),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .write_finish (write_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic        chk_on = 1'b0;
  logic [31:0] mm [0:DEPTH-1];
  logic        exp_rv = 1'b0, exp_wf = 1'b0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
  endtask

  always @(negedge clk)
    if (chk_on) begin
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      chk("write_finish", 32'(write_finish), 32'(exp_wf));
      chk("rdata", rdata, exp_rd);
    end

  // mode: 0 end by is_fire, 1 end by dropping en, 2 end by async reset in DONE,
  //       3 flush (en low before edge k after acceptance), 4 async reset during BUSY
  task automatic tx(input logic w, input logic [31:0] a, input logic [3:0] m,
                    input logic [31:0] d, input int hold, input int mode, input int k,
                    output logic [31:0] rd);
    int          idx;
    logic [31:0] bm;
    rd = 32'h0;
    en = 1'b1; we = w; addr = a; wmask = m; wdata = d; is_fire = 1'b0;
    @(posedge clk); #1;
    // Inputs after acceptance must be ignored; is_fire outside DONE too.
    we = ~w; addr = $urandom; wmask = 4'($urandom); wdata = $urandom; is_fire = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      if (mode == 3 && e == k) begin
        en = 1'b0; is_fire = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (mode == 4 && e == k) begin
        reset = 1'b1; #1; reset = 1'b0;
        en = 1'b0; is_fire = 1'b0; exp_rd = 32'h0;
        return;
      end
      @(posedge clk); #1;
    end
    is_fire = 1'b0;
    idx = int'((a >> 2) & 32'(DEPTH - 1));
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{m[i]}};
    if (w) begin
      mm[idx] = (mm[idx] & ~bm) | (d & bm);
      exp_wf  = 1'b1;
    end else begin
      exp_rd = mm[idx];
      exp_rv = 1'b1;
    end
    rd = rdata;
    repeat (hold) begin @(posedge clk); #1; end
    case (mode)
      0: begin
        is_fire = 1'b1;
        @(posedge clk); #1;
        is_fire = 1'b0; en = 1'b0; exp_rv = 1'b0; exp_wf = 1'b0;
      end
      1: begin
        en = 1'b0;
        @(posedge clk); #1;
        exp_rv = 1'b0; exp_wf = 1'b0;
      end
      default: begin
        #1 reset = 1'b1; #1;
        chk("async_rv", 32'(rdata_valid), 32'h0);
        chk("async_wf", 32'(write_finish), 32'h0);
        chk("async_rd", rdata, 32'h0);
        reset = 1'b0; en = 1'b0;
        exp_rv = 1'b0; exp_wf = 1'b0; exp_rd = 32'h0;
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    reset = 1'b1; en = 1'b0; we = 1'b0; addr = 32'h0; wmask = 4'h0;
    wdata = 32'h0; is_fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rv", 32'(rdata_valid), 32'h0);
    chk("reset_wf", 32'(write_finish), 32'h0);
    chk("reset_rd", rdata, 32'h0);
    reset = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // store/load round trip, long hold on the load
    tx(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2, 0, 0, got);
    tx(1'b0, 32'h10, 4'h0, 32'h0, 5, 0, 0, got);
    chk("lit_rt", got, 32'hDEADBEEF);

    // byte-lane store; first store ends by dropping en and stays committed
    tx(1'b1, 32'h20, 4'hF, 32'h11223344, 1, 1, 0, got);
    tx(1'b1, 32'h20, 4'b0010, 32'h0000AA00, 0, 0, 0, got);
    tx(1'b0, 32'h20, 4'h0, 32'h0, 1, 0, 0, got);
    chk("lit_lane", got, 32'h1122AA44);

    // flush during BUSY leaves prior contents
    tx(1'b1, 32'h40, 4'hF, 32'h00000099, 0, 0, 0, got);
    tx(1'b1, 32'h40, 4'hF, 32'h00000055, 0, 3, 3, got);
    tx(1'b0, 32'h40, 4'h0, 32'h0, 0, 0, 0, got);
    chk("lit_flush", got, 32'h00000099);

    // address wrap
    tx(1'b1, 32'h00001004, 4'hF, 32'h12345678, 0, 0, 0, got);
    tx(1'b0, 32'h00000004, 4'h0, 32'h0, 0, 1, 0, got);
    chk("lit_wrap", got, 32'h12345678);

    // zero-mask store: write_finish pulses, array unchanged
    tx(1'b1, 32'h4, 4'h0, 32'hFFFFFFFF, 1, 0, 0, got);
    tx(1'b0, 32'h4, 4'h0, 32'h0, 0, 0, 0, got);
    chk("lit_mask0", got, 32'h12345678);

    // reset during BUSY discards the store
    tx(1'b1, 32'h10, 4'hF, 32'h0, 0, 4, 2, got);
    tx(1'b0, 32'h10, 4'h0, 32'h0, 0, 0, 0, got);
    chk("lit_rst_busy", got, 32'hDEADBEEF);

    // async reset while a load response is held
    tx(1'b0, 32'h1004, 4'h0, 32'h0, 2, 2, 0, got);
    @(posedge clk); #1;

    // top word, split mask, unaligned load address
    tx(1'b1, 32'hFFC, 4'hF, 32'hA5A5A5A5, 0, 0, 0, got);
    tx(1'b1, 32'hFFD, 4'b1001, 32'h12000034, 0, 1, 0, got);
    tx(1'b0, 32'hFFE, 4'h0, 32'h0, 0, 0, 0, got);
    chk("lit_top", got, 32'h12A5A534);
    tx(1'b0, 32'h23, 4'h0, 32'h0, 0, 0, 0, got);
    chk("lit_unaligned", got, 32'h1122AA44);

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
